// File: rtl/ddr4_cmd_responder.sv
// DDR4 command-bus responder: decodes commands, tracks per-bank open state and
// ACT/PRE timing, flags illegal commands and generates BL8 read/write data windows.
module ddr4_cmd_responder #(
  parameter int CL   = 16,
  parameter int CWL  = 12,
  parameter int TRCD = 16,
  parameter int TRP  = 16,
  parameter int TRAS = 39
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        CS_n,
  input  logic        ACT_n,
  input  logic        RAS_n_A16,
  input  logic        CAS_n_A15,
  input  logic        WE_n_A14,
  input  logic [1:0]  BG,
  input  logic [1:0]  BA,
  input  logic [13:0] ADDR,
  output logic [15:0] bank_open,
  output logic        rd_data_en,
  output logic        wr_data_en,
  output logic [3:0]  burst_bank,
  output logic [16:0] burst_row,
  output logic [9:0]  burst_col,
  output logic        cmd_err,
  output logic [2:0]  err_code
);

  typedef enum logic [3:0] {
    CMD_DES, CMD_ACT, CMD_MRS, CMD_REF, CMD_PRE, CMD_PREA,
    CMD_WR, CMD_RD, CMD_ZQ, CMD_NOP, CMD_RSVD
  } cmd_e;

  typedef struct packed {
    logic [3:0]  bank;
    logic [16:0] row;
    logic [9:0]  col;
  } burst_t;

  localparam int RD_LEN = CL + 3;
  localparam int WR_LEN = CWL + 3;
  localparam int COL_SPACING = 4;

  logic [15:0]       open_q, open_d;
  logic [16:0]       row_q [16];
  logic [16:0]       row_d [16];
  logic [7:0]        act_cnt_q [16];
  logic [7:0]        act_cnt_d [16];
  logic [7:0]        pre_cnt_q [16];
  logic [7:0]        pre_cnt_d [16];
  logic [7:0]        col_cnt_q, col_cnt_d;
  logic [RD_LEN-1:0] rd_vld_q, rd_vld_d;
  logic [WR_LEN-1:0] wr_vld_q, wr_vld_d;
  burst_t            rd_pay_q [CL];
  burst_t            rd_pay_d [CL];
  burst_t            wr_pay_q [CWL];
  burst_t            wr_pay_d [CWL];
  burst_t            burst_q, burst_d, cur_burst;
  logic              rd_en_q, rd_en_d, wr_en_q, wr_en_d;
  logic              cmd_err_q, cmd_err_d;
  logic [2:0]        err_code_q, err_code_d, err_val;
  logic              rd_issue, wr_issue, tras_viol_any;
  cmd_e              cmd;
  logic [3:0]        bank;
  logic [16:0]       act_row;

  function automatic logic [7:0] sat_inc(input logic [7:0] c);
    return (c == 8'hFF) ? c : c + 8'd1;
  endfunction

  // A counter reads 0 on the cycle after its event, so edges elapsed is c+1.
  function automatic logic elapsed(input logic [7:0] c, input int t);
    return (int'(c) + 1) >= t;
  endfunction

  assign bank      = {BG, BA};
  assign act_row   = {RAS_n_A16, CAS_n_A15, WE_n_A14, ADDR};
  assign cur_burst = {bank, row_q[bank], ADDR[9:0]};

  always_comb begin
    cmd = CMD_DES;
    if (!CS_n) begin
      if (!ACT_n) begin
        cmd = CMD_ACT;
      end else begin
        case ({RAS_n_A16, CAS_n_A15, WE_n_A14})
          3'b000:  cmd = CMD_MRS;
          3'b001:  cmd = CMD_REF;
          3'b010:  cmd = ADDR[10] ? CMD_PREA : CMD_PRE;
          3'b011:  cmd = CMD_RSVD;
          3'b100:  cmd = CMD_WR;
          3'b101:  cmd = CMD_RD;
          3'b110:  cmd = CMD_ZQ;
          default: cmd = CMD_NOP;
        endcase
      end
    end
  end

  // NOTE: every signal written here gets a default first so no path leaves one unassigned (no latch).
  always_comb begin
    open_d        = open_q;
    col_cnt_d     = sat_inc(col_cnt_q);
    err_val       = 3'd0;
    rd_issue      = 1'b0;
    wr_issue      = 1'b0;
    tras_viol_any = 1'b0;
    for (int i = 0; i < 16; i++) begin
      row_d[i]     = row_q[i];
      act_cnt_d[i] = sat_inc(act_cnt_q[i]);
      pre_cnt_d[i] = sat_inc(pre_cnt_q[i]);
      if (open_q[i] && !elapsed(act_cnt_q[i], TRAS)) tras_viol_any = 1'b1;
    end

    // Checks are ordered by error code so the lowest applicable code wins.
    case (cmd)
      CMD_ACT: begin
        if (open_q[bank])                        err_val = 3'd1;
        else if (!elapsed(pre_cnt_q[bank], TRP)) err_val = 3'd2;
        else begin
          open_d[bank]    = 1'b1;
          row_d[bank]     = act_row;
          act_cnt_d[bank] = 8'd0;
        end
      end
      CMD_RD, CMD_WR: begin
        if (!open_q[bank])                                err_val = 3'd3;
        else if (!elapsed(act_cnt_q[bank], TRCD))         err_val = 3'd4;
        else if (!elapsed(col_cnt_q, COL_SPACING))        err_val = 3'd6;
        else begin
          rd_issue  = (cmd == CMD_RD);
          wr_issue  = (cmd == CMD_WR);
          col_cnt_d = 8'd0;
        end
      end
      CMD_PRE: begin
        if (open_q[bank]) begin
          if (!elapsed(act_cnt_q[bank], TRAS)) err_val = 3'd5;
          else begin
            open_d[bank]    = 1'b0;
            pre_cnt_d[bank] = 8'd0;
          end
        end
      end
      CMD_PREA: begin
        if (tras_viol_any) err_val = 3'd5;
        else begin
          for (int i = 0; i < 16; i++) begin
            if (open_q[i]) begin
              open_d[i]    = 1'b0;
              pre_cnt_d[i] = 8'd0;
            end
          end
        end
      end
      CMD_REF:  if (|open_q) err_val = 3'd7;
      CMD_RSVD: err_val = 3'd7;
      default:  ;
    endcase

    cmd_err_d  = (err_val != 3'd0);
    err_code_d = cmd_err_d ? err_val : err_code_q;
  end

  // Burst delay lines: a valid bit walks the line and opens a 4-beat window at the latency tap.
  always_comb begin
    rd_vld_d    = {rd_vld_q[RD_LEN-2:0], rd_issue};
    wr_vld_d    = {wr_vld_q[WR_LEN-2:0], wr_issue};
    rd_en_d     = |rd_vld_q[RD_LEN-1:CL-1];
    wr_en_d     = |wr_vld_q[WR_LEN-1:CWL-1];
    rd_pay_d[0] = cur_burst;
    wr_pay_d[0] = cur_burst;
    for (int i = 1; i < CL; i++)  rd_pay_d[i] = rd_pay_q[i-1];
    for (int i = 1; i < CWL; i++) wr_pay_d[i] = wr_pay_q[i-1];
    // If a read and a write window open on the same edge, the write (issued later) owns the burst fields.
    burst_d = burst_q;
    if (rd_vld_q[CL-1])  burst_d = rd_pay_q[CL-1];
    if (wr_vld_q[CWL-1]) burst_d = wr_pay_q[CWL-1];
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      open_q     <= '0;
      col_cnt_q  <= 8'hFF;
      rd_vld_q   <= '0;
      wr_vld_q   <= '0;
      rd_en_q    <= 1'b0;
      wr_en_q    <= 1'b0;
      burst_q    <= '0;
      cmd_err_q  <= 1'b0;
      err_code_q <= 3'd0;
      for (int i = 0; i < 16; i++) begin
        act_cnt_q[i] <= 8'hFF;
        pre_cnt_q[i] <= 8'hFF;
      end
    end else begin
      open_q     <= open_d;
      col_cnt_q  <= col_cnt_d;
      rd_vld_q   <= rd_vld_d;
      wr_vld_q   <= wr_vld_d;
      rd_en_q    <= rd_en_d;
      wr_en_q    <= wr_en_d;
      burst_q    <= burst_d;
      cmd_err_q  <= cmd_err_d;
      err_code_q <= err_code_d;
      act_cnt_q  <= act_cnt_d;
      pre_cnt_q  <= pre_cnt_d;
    end
  end

  // NOTE: rows and payload lines are storage gated by open/valid flags, so they are left without reset.
  always_ff @(posedge CLK) begin
    row_q    <= row_d;
    rd_pay_q <= rd_pay_d;
    wr_pay_q <= wr_pay_d;
  end

  assign bank_open  = open_q;
  assign rd_data_en = rd_en_q;
  assign wr_data_en = wr_en_q;
  assign burst_bank = burst_q.bank;
  assign burst_row  = burst_q.row;
  assign burst_col  = burst_q.col;
  assign cmd_err    = cmd_err_q;
  assign err_code   = err_code_q;

endmodule

// File: tb/tb_ddr4_cmd_responder.sv
// Directed bench for ddr4_cmd_responder with default timing parameters.
module tb_ddr4_cmd_responder;

  logic        CLK = 1'b0;
  logic        nRST = 1'b0;
  logic        CS_n = 1'b1, ACT_n = 1'b1, RAS_n_A16 = 1'b1, CAS_n_A15 = 1'b1, WE_n_A14 = 1'b1;
  logic [1:0]  BG = '0, BA = '0;
  logic [13:0] ADDR = '0;
  logic [15:0] bank_open;
  logic        rd_data_en, wr_data_en, cmd_err;
  logic [3:0]  burst_bank;
  logic [16:0] burst_row;
  logic [9:0]  burst_col;
  logic [2:0]  err_code;

  int checks = 0;
  int errors = 0;

  ddr4_cmd_responder dut (
    .CLK(CLK), .nRST(nRST), .CS_n(CS_n), .ACT_n(ACT_n),
    .RAS_n_A16(RAS_n_A16), .CAS_n_A15(CAS_n_A15), .WE_n_A14(WE_n_A14),
    .BG(BG), .BA(BA), .ADDR(ADDR),
    .bank_open(bank_open), .rd_data_en(rd_data_en), .wr_data_en(wr_data_en),
    .burst_bank(burst_bank), .burst_row(burst_row), .burst_col(burst_col),
    .cmd_err(cmd_err), .err_code(err_code)
  );

  always #5 CLK = ~CLK;

  task automatic idle(input int n);
    repeat (n) begin @(posedge CLK); #1; end
  endtask

  // Drives one command for exactly one rising edge, then returns the bus to DES.
  task automatic drive(input logic act_n, input logic ras, input logic cas, input logic we,
                       input logic [3:0] bank, input logic [13:0] addr);
    CS_n = 1'b0; ACT_n = act_n; RAS_n_A16 = ras; CAS_n_A15 = cas; WE_n_A14 = we;
    BG = bank[3:2]; BA = bank[1:0]; ADDR = addr;
    @(posedge CLK); #1;
    CS_n = 1'b1; ACT_n = 1'b1; RAS_n_A16 = 1'b1; CAS_n_A15 = 1'b1; WE_n_A14 = 1'b1;
    BG = '0; BA = '0; ADDR = '0;
  endtask

  task automatic do_act(input logic [3:0] bank, input logic [16:0] row);
    drive(1'b0, row[16], row[15], row[14], bank, row[13:0]);
  endtask
  task automatic do_rd(input logic [3:0] bank, input logic [9:0] col);
    drive(1'b1, 1'b1, 1'b0, 1'b1, bank, {4'd0, col});
  endtask
  task automatic do_wr(input logic [3:0] bank, input logic [9:0] col);
    drive(1'b1, 1'b1, 1'b0, 1'b0, bank, {4'd0, col});
  endtask
  task automatic do_pre(input logic [3:0] bank);
    drive(1'b1, 1'b0, 1'b1, 1'b0, bank, 14'h0000);
  endtask
  task automatic do_prea();
    drive(1'b1, 1'b0, 1'b1, 1'b0, 4'd0, 14'h0400);
  endtask
  task automatic do_ref();
    drive(1'b1, 1'b0, 1'b0, 1'b1, 4'd0, 14'h0000);
  endtask

  task automatic apply_reset();
    nRST = 1'b0;
    idle(2);
    nRST = 1'b1;
    idle(1);
  endtask

  task automatic test_reset();
    nRST = 1'b0;
    idle(3);
    checks++;
    if ({bank_open, rd_data_en, wr_data_en, cmd_err, err_code} !== 22'd0) begin
      errors++;
      $display("FAIL reset_ctrl: got open=%h rd=%b wr=%b err=%b code=%0d, expected all 0",
               bank_open, rd_data_en, wr_data_en, cmd_err, err_code);
    end
    checks++;
    if ({burst_bank, burst_row, burst_col} !== 31'd0) begin
      errors++;
      $display("FAIL reset_burst: got bank=%h row=%h col=%h, expected 0", burst_bank, burst_row, burst_col);
    end
    nRST = 1'b1;
    idle(1);
  endtask

  task automatic test_read();
    apply_reset();
    do_act(4'd6, 17'h0AAAA);                 // t0
    checks++;
    if (cmd_err !== 1'b0 || bank_open !== 16'h0040) begin
      errors++;
      $display("FAIL read_act: got err=%b open=%h, expected 0 / 0040", cmd_err, bank_open);
    end
    idle(15);
    do_rd(4'd6, 10'h0A8);                    // t0+16
    checks++;
    if (cmd_err !== 1'b0) begin
      errors++; $display("FAIL read_cmd_err: got %b expected 0", cmd_err);
    end
    idle(15);                                // t0+31
    checks++;
    if (rd_data_en !== 1'b0) begin
      errors++; $display("FAIL read_early: rd_data_en got %b expected 0", rd_data_en);
    end
    for (int b = 0; b < 4; b++) begin        // t0+32..t0+35
      idle(1);
      checks++;
      if (rd_data_en !== 1'b1 || burst_bank !== 4'd6 || burst_row !== 17'h0AAAA || burst_col !== 10'h0A8) begin
        errors++;
        $display("FAIL read_beat%0d: got en=%b bank=%h row=%h col=%h, expected 1/6/0aaaa/0a8",
                 b, rd_data_en, burst_bank, burst_row, burst_col);
      end
    end
    idle(1);                                 // t0+36
    checks++;
    if (rd_data_en !== 1'b0 || bank_open !== 16'h0040) begin
      errors++;
      $display("FAIL read_end: got en=%b open=%h, expected 0 / 0040", rd_data_en, bank_open);
    end
  endtask

  task automatic test_write_trcd();
    apply_reset();
    do_act(4'd0, 17'h00123);                 // t0
    idle(9);
    do_wr(4'd0, 10'h010);                    // t0+10
    checks++;
    if (cmd_err !== 1'b1 || err_code !== 3'd4) begin
      errors++; $display("FAIL wr_trcd: got err=%b code=%0d, expected 1 / 4", cmd_err, err_code);
    end
    idle(1);
    checks++;
    if (cmd_err !== 1'b0 || err_code !== 3'd4) begin
      errors++; $display("FAIL wr_err_pulse: got err=%b code=%0d, expected 0 / 4 held", cmd_err, err_code);
    end
    idle(4);
    do_wr(4'd0, 10'h020);                    // t0+16
    checks++;
    if (cmd_err !== 1'b0) begin
      errors++; $display("FAIL wr_legal: cmd_err got %b expected 0", cmd_err);
    end
    idle(6);                                 // t0+22, where the rejected WR would have started
    checks++;
    if (wr_data_en !== 1'b0) begin
      errors++; $display("FAIL wr_rejected_quiet: wr_data_en got %b expected 0", wr_data_en);
    end
    idle(5);                                 // t0+27
    checks++;
    if (wr_data_en !== 1'b0) begin
      errors++; $display("FAIL wr_early: wr_data_en got %b expected 0", wr_data_en);
    end
    for (int b = 0; b < 4; b++) begin        // t0+28..t0+31
      idle(1);
      checks++;
      if (wr_data_en !== 1'b1 || burst_col !== 10'h020 || burst_row !== 17'h00123) begin
        errors++;
        $display("FAIL wr_beat%0d: got en=%b row=%h col=%h, expected 1/00123/020", b, wr_data_en, burst_row, burst_col);
      end
    end
    idle(1);
    checks++;
    if (wr_data_en !== 1'b0 || rd_data_en !== 1'b0) begin
      errors++; $display("FAIL wr_end: got wr=%b rd=%b expected 0/0", wr_data_en, rd_data_en);
    end
  endtask

  task automatic test_precharge();
    apply_reset();
    do_act(4'd0, 17'h00001);                 // t0
    idle(19);
    do_pre(4'd0);                            // t0+20
    checks++;
    if (cmd_err !== 1'b1 || err_code !== 3'd5 || bank_open !== 16'h0001) begin
      errors++;
      $display("FAIL pre_tras: got err=%b code=%0d open=%h, expected 1/5/0001", cmd_err, err_code, bank_open);
    end
    idle(18);
    do_pre(4'd0);                            // t0+39
    checks++;
    if (cmd_err !== 1'b0 || bank_open !== 16'h0000) begin
      errors++; $display("FAIL pre_legal: got err=%b open=%h, expected 0/0000", cmd_err, bank_open);
    end
    idle(10);
    do_act(4'd0, 17'h00002);                 // t0+50
    checks++;
    if (cmd_err !== 1'b1 || err_code !== 3'd2 || bank_open !== 16'h0000) begin
      errors++;
      $display("FAIL act_trp: got err=%b code=%0d open=%h, expected 1/2/0000", cmd_err, err_code, bank_open);
    end
    idle(4);
    do_act(4'd0, 17'h00002);                 // t0+55
    checks++;
    if (cmd_err !== 1'b0 || bank_open !== 16'h0001) begin
      errors++; $display("FAIL act_after_trp: got err=%b open=%h, expected 0/0001", cmd_err, bank_open);
    end
  endtask

  task automatic test_back_to_back();
    apply_reset();
    do_act(4'd0, 17'h00055);                 // t0
    idle(15);
    do_rd(4'd0, 10'h001);                    // t1 = t0+16
    idle(3);
    do_rd(4'd0, 10'h002);                    // t1+4
    checks++;
    if (cmd_err !== 1'b0) begin
      errors++; $display("FAIL b2b_second_rd: cmd_err got %b expected 0", cmd_err);
    end
    idle(1);
    do_rd(4'd0, 10'h003);                    // t1+6
    checks++;
    if (cmd_err !== 1'b1 || err_code !== 3'd6) begin
      errors++; $display("FAIL b2b_spacing: got err=%b code=%0d, expected 1/6", cmd_err, err_code);
    end
    idle(9);                                 // t1+15
    checks++;
    if (rd_data_en !== 1'b0) begin
      errors++; $display("FAIL b2b_early: rd_data_en got %b expected 0", rd_data_en);
    end
    for (int b = 0; b < 8; b++) begin        // t1+16..t1+23
      idle(1);
      checks++;
      if (rd_data_en !== 1'b1 || burst_col !== ((b < 4) ? 10'h001 : 10'h002)) begin
        errors++;
        $display("FAIL b2b_beat%0d: got en=%b col=%h, expected 1 / %h", b, rd_data_en, burst_col,
                 (b < 4) ? 10'h001 : 10'h002);
      end
    end
    idle(1);                                 // t1+24
    checks++;
    if (rd_data_en !== 1'b0) begin
      errors++; $display("FAIL b2b_end: rd_data_en got %b expected 0", rd_data_en);
    end
  endtask

  task automatic test_refresh();
    apply_reset();
    do_act(4'd3, 17'h10000);                 // t0
    do_ref();                                // t0+1
    checks++;
    if (cmd_err !== 1'b1 || err_code !== 3'd7) begin
      errors++; $display("FAIL ref_open: got err=%b code=%0d, expected 1/7", cmd_err, err_code);
    end
    do_prea();                               // t0+2
    checks++;
    if (cmd_err !== 1'b1 || err_code !== 3'd5 || bank_open !== 16'h0008) begin
      errors++;
      $display("FAIL prea_tras: got err=%b code=%0d open=%h, expected 1/5/0008", cmd_err, err_code, bank_open);
    end
    idle(36);
    do_prea();                               // t0+39
    checks++;
    if (cmd_err !== 1'b0 || bank_open !== 16'h0000) begin
      errors++; $display("FAIL prea_legal: got err=%b open=%h, expected 0/0000", cmd_err, bank_open);
    end
    do_ref();                                // t0+40
    checks++;
    if (cmd_err !== 1'b0 || err_code !== 3'd5 || bank_open !== 16'h0000) begin
      errors++;
      $display("FAIL ref_legal: got err=%b code=%0d open=%h, expected 0/5/0000", cmd_err, err_code, bank_open);
    end
  endtask

  task automatic test_priority();
    apply_reset();
    do_act(4'd0, 17'h00777);                 // t0
    idle(15);
    do_rd(4'd0, 10'h003);                    // t0+16, accepted
    do_rd(4'd5, 10'h004);                    // closed bank and spacing both apply
    checks++;
    if (cmd_err !== 1'b1 || err_code !== 3'd3) begin
      errors++; $display("FAIL prio_closed: got err=%b code=%0d, expected 1/3", cmd_err, err_code);
    end
    drive(1'b1, 1'b0, 1'b1, 1'b1, 4'd0, 14'h0000);   // reserved encoding
    checks++;
    if (cmd_err !== 1'b1 || err_code !== 3'd7) begin
      errors++; $display("FAIL reserved: got err=%b code=%0d, expected 1/7", cmd_err, err_code);
    end
    drive(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 14'h0000);   // MRS
    checks++;
    if (cmd_err !== 1'b0 || err_code !== 3'd7 || bank_open !== 16'h0001) begin
      errors++;
      $display("FAIL mrs_noop: got err=%b code=%0d open=%h, expected 0/7/0001", cmd_err, err_code, bank_open);
    end
    do_act(4'd0, 17'h00001);
    checks++;
    if (cmd_err !== 1'b1 || err_code !== 3'd1) begin
      errors++; $display("FAIL act_open: got err=%b code=%0d, expected 1/1", cmd_err, err_code);
    end
  endtask

  task automatic test_reset_midburst();
    logic seen;
    apply_reset();
    do_act(4'd0, 17'h00009);                 // t0
    idle(15);
    do_rd(4'd0, 10'h011);                    // t1
    idle(17);                                // t1+17, second beat
    checks++;
    if (rd_data_en !== 1'b1) begin
      errors++; $display("FAIL midburst_pre: rd_data_en got %b expected 1", rd_data_en);
    end
    nRST = 1'b0;
    #1;
    checks++;
    if (rd_data_en !== 1'b0 || bank_open !== 16'h0000) begin
      errors++;
      $display("FAIL midburst_async: got en=%b open=%h, expected 0/0000", rd_data_en, bank_open);
    end
    idle(2);
    nRST = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 24; c++) begin
      idle(1);
      if (rd_data_en !== 1'b0 || wr_data_en !== 1'b0) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++; $display("FAIL midburst_flush: data enable activity after reset, got %b expected 0", seen);
    end
  endtask

  initial begin
    test_reset();
    test_read();
    test_write_trcd();
    test_precharge();
    test_back_to_back();
    test_refresh();
    test_priority();
    test_reset_midburst();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ddr4_cmd_responder.md
DDR4_CMD_RESPONDER -- requirements
Module: ddr4_cmd_responder

Interface
REQ-001 SHALL have one clock and an asynchronous active-low reset: CLK input 1 is the command clock, sampled on the rising edge; nRST input 1 is the async active-low reset.
REQ-002 SHALL take these parameters (name, default, meaning): CL, 16, read latency in CLK; CWL, 12, write latency in CLK; TRCD, 16, ACT-to-RD/WR minimum; TRP, 16, PRE-to-ACT minimum; TRAS, 39, ACT-to-PRE minimum.
REQ-003 SHALL have these inputs (name, direction, width, meaning):
- CS_n, ACT_n, RAS_n_A16, CAS_n_A15, WE_n_A14: input, 1 each, DDR4 command pins.
- BG, BA: input, 2 each, bank group and bank.
- ADDR: input, 14, A13..A0.
REQ-004 SHALL have these outputs (name, direction, width, meaning):
- bank_open: output, 16, bit {BG,BA} set while that bank is active.
- rd_data_en: output, 1, read burst data-out window.
- wr_data_en: output, 1, write burst data-capture window.
- burst_bank: output, 4, {BG,BA} of the current burst.
- burst_row: output, 17, open row of the current burst.
- burst_col: output, 10, column of the current burst.
- cmd_err: output, 1, one-cycle illegal-command pulse.
- err_code: output, 3, cause of the error, held until the next error.

Function
REQ-005 SHALL decode only when CS_n=0; CS_n=1 is DES.
- ACT_n=0 is ACT, row = {RAS_n_A16, CAS_n_A15, WE_n_A14, ADDR}.
- With ACT_n=1, {RAS,CAS,WE} decodes as: 000 MRS, 001 REF, 010 PRE (ADDR[10]=1 means PREA), 100 WR, 101 RD, 110 ZQ, 111 NOP, 011 reserved.
REQ-006 SHALL keep per bank: open flag, 17-bit open row, 8-bit saturating counter since last ACT, 8-bit saturating counter since last PRE.
REQ-007 ACT to a closed bank whose PRE counter is >= TRP SHALL set the open flag, store the row and clear the ACT counter.
REQ-008 PRE to an open bank whose ACT counter is >= TRAS SHALL clear the open flag and clear the PRE counter. PRE to a closed bank SHALL be a legal no-op.
REQ-009 PREA SHALL apply REQ-008 to all banks. It is rejected entirely if any open bank violates TRAS.
REQ-010 RD/WR SHALL be legal only when all of these hold: the bank is open; its ACT counter is >= TRCD; at least 4 cycles have elapsed since the previous accepted RD/WR.
REQ-011 RD accepted at edge t SHALL assert rd_data_en for edges t+CL through t+CL+3 (4 cycles, BL8). WR SHALL do the same on wr_data_en using CWL.
REQ-012 During each burst window, burst_bank/row/col SHALL hold the issuing command's values; outside windows they hold their last values.
REQ-013 Accepted column commands SHALL be delay-lined so back-to-back RD at 4-cycle spacing gives a continuous rd_data_en.
- RD followed by WR is legal at 4-cycle spacing.
- Overlapping rd_data_en and wr_data_en is permitted and is not checked.
REQ-014 Any illegal command SHALL pulse cmd_err at the next edge, load err_code, and cause no state change. err_code values:
- 1: ACT to an open bank.
- 2: ACT before TRP.
- 3: RD/WR to a closed bank.
- 4: RD/WR before TRCD.
- 5: PRE/PREA before TRAS.
- 6: RD/WR before 4-cycle spacing.
- 7: REF with any bank open, or a reserved encoding.
When several causes apply, the lowest code SHALL win.
REQ-015 MRS, ZQ, NOP, DES and a legal REF SHALL change no bank state.
REQ-016 All counters SHALL saturate at 255; they SHALL never wrap.

Reset
REQ-017 While nRST=0, the block SHALL be held in reset:
- All outputs are 0.
- All banks are closed.
- All ACT/PRE counters and the column-spacing counter are 255, so the first ACT and the first column command after reset are legal.
REQ-018 Reset asserted mid-burst SHALL immediately drop rd_data_en/wr_data_en and flush the delay lines. No burst resumes after release.

Verification
REQ-019 ACT BG=1 BA=2 row 0x0AAAA at t0; RD col 0x0A8 at t0+16 -> bank_open[6]=1; rd_data_en high at t0+32..t0+35 with burst_row=0x0AAAA, burst_col=0x0A8; cmd_err=0.
REQ-020 ACT bank 0 at t0; WR at t0+10 -> cmd_err pulse, err_code=4, wr_data_en stays 0. WR at t0+16 -> wr_data_en high at t0+28..t0+31.
REQ-021 ACT bank 0 at t0; PRE at t0+20 -> err_code=5, bank stays open. PRE at t0+39 -> bank_open[0]=0. ACT at t0+50 -> err_code=2. ACT at t0+55 -> accepted.
REQ-022 RD bank 0 at t1 and again at t1+4 -> rd_data_en continuous for 8 cycles. A third RD at t1+6 -> err_code=6.
REQ-023 REF with bank 3 open -> err_code=7. PREA after TRAS, then REF -> no error, bank_open=0.
REQ-024 nRST pulsed low during the 2nd beat of a read window -> rd_data_en=0 at once, bank_open=0, no further data-enable activity afterwards.
